// File: rtl/dircc_pll_reset_ctrl_pkg.sv
// Shared definitions for the PLL reset controller: state encoding,
// default counter width and a constant helper for timer sizing.
package dircc_pll_reset_ctrl_pkg;

    localparam logic [1:0] ST_PLL_RESET = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABLE    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam int CNT_W_DEF = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dircc_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous status bit.
// Also reused for crossing PLL status into the Nios domain.
module dircc_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dircc_pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for stable lock,
// then releases the system reset; counts timeouts and lock losses.
module dircc_pll_reset_ctrl
    import dircc_pll_reset_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int CNT_W               = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clear_counts,
    output logic             pll_rst,
    output logic             reset_out,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int MAX_CYC = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES);
    localparam int TMR_W = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] STB_DONE = TMR_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             locked_s;
    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] ll_cnt_q, ll_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             pll_rst_q, reset_out_q, ready_q;
    logic             ll_evt, to_evt;

    dircc_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    always_comb begin
        state_d = state_q;
        ll_evt  = 1'b0;
        to_evt  = 1'b0;
        case (state_q)
            ST_PLL_RESET: begin
                if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout cycle takes priority
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_PLL_RESET;
                    to_evt  = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (timer_q == STB_DONE) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_PLL_RESET;
                    ll_evt  = 1'b1;
                end
            end
            default: state_d = ST_PLL_RESET;
        endcase

        if (state_d != state_q || state_q == ST_RUN) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_comb begin
        ll_cnt_d = ll_cnt_q;
        to_cnt_d = to_cnt_q;
        if (clear_counts) begin
            ll_cnt_d = '0;
            to_cnt_d = '0;
        end else begin
            if (ll_evt && ll_cnt_q != CNT_MAX) ll_cnt_d = ll_cnt_q + 1'b1;
            if (to_evt && to_cnt_q != CNT_MAX) to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PLL_RESET;
            timer_q     <= '0;
            ll_cnt_q    <= '0;
            to_cnt_q    <= '0;
            pll_rst_q   <= 1'b1;
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ll_cnt_q    <= ll_cnt_d;
            to_cnt_q    <= to_cnt_d;
            pll_rst_q   <= (state_d == ST_PLL_RESET);
            reset_out_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign reset_out       = reset_out_q;
    assign ready           = ready_q;
    assign lock_loss_count = ll_cnt_q;
    assign timeout_count   = to_cnt_q;

endmodule

// File: tb/tb_dircc_pll_reset_ctrl.sv
// Self-checking bench for dircc_pll_reset_ctrl: directed scenarios plus
// randomized lock traffic against a cycle-level behavioural model.
module tb_dircc_pll_reset_ctrl;

    localparam int SYNC = 2;
    localparam int RSTC = 4;
    localparam int LSC  = 8;
    localparam int TO   = 32;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam int P_RES  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          clear_counts;
    logic          pll_rst;
    logic          reset_out;
    logic          ready;
    logic [CW-1:0] lock_loss_count;
    logic [CW-1:0] timeout_count;

    always #5 clk = ~clk;

    dircc_pll_reset_ctrl #(
        .SYNC_STAGES         (SYNC),
        .PLL_RST_CYCLES      (RSTC),
        .LOCK_STABLE_CYCLES  (LSC),
        .LOCK_TIMEOUT_CYCLES (TO),
        .CNT_W               (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .clear_counts    (clear_counts),
        .pll_rst         (pll_rst),
        .reset_out       (reset_out),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .timeout_count   (timeout_count)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, time spent in phase, counters, and the
    // history of pll_locked samples (locked_s is the sample SYNC edges old).
    int m_phase = P_RES;
    int m_age   = 0;
    int m_ll    = 0;
    int m_to    = 0;
    int m_hist[$];

    task automatic model_step();
        int ls;
        int nxt;
        ls = m_hist[SYNC-1];
        if (rst === 1'b1) begin
            m_phase = P_RES;
            m_age   = 0;
            m_ll    = 0;
            m_to    = 0;
            m_hist.delete();
            repeat (SYNC) m_hist.push_back(0);
        end else begin
            nxt = m_phase;
            case (m_phase)
                P_RES: if (m_age + 1 >= RSTC) nxt = P_WAIT;
                P_WAIT: begin
                    if (ls == 1) nxt = P_STB;
                    else if (m_age + 1 >= TO) begin
                        nxt = P_RES;
                        if (m_to < MAXC) m_to++;
                    end
                end
                P_STB: begin
                    if (ls == 0) nxt = P_WAIT;
                    else if (m_age + 1 > LSC) nxt = P_RUN;
                end
                default: begin
                    if (ls == 0) begin
                        nxt = P_RES;
                        if (m_ll < MAXC) m_ll++;
                    end
                end
            endcase
            if (clear_counts === 1'b1) begin
                m_ll = 0;
                m_to = 0;
            end
            m_age   = (nxt == m_phase) ? m_age + 1 : 0;
            m_phase = nxt;
            m_hist.push_front((pll_locked === 1'b1) ? 1 : 0);
            void'(m_hist.pop_back());
        end
    endtask

    initial begin
        repeat (SYNC) m_hist.push_back(0);
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_pll_rst", pll_rst, m_phase == P_RES);
                check("cyc_reset_out", reset_out, m_phase != P_RUN);
                check("cyc_ready", ready, m_phase == P_RUN);
                check("cyc_lock_loss", lock_loss_count, m_ll);
                check("cyc_timeout", timeout_count, m_to);
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return ready;
            1:       return pll_rst;
            default: return reset_out;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input int limit,
                            input string nm, output int n);
        n = 0;
        while (sig(which) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(nm, sig(which), val);
    endtask

    int n, cnt, lo, hi, tot, rel, hold;

    initial begin
        rst          = 1'b1;
        pll_locked   = 1'b0;
        clear_counts = 1'b0;
        @(negedge clk);
        chk_en = 1;
        check("rst_pll_rst", pll_rst, 1);
        check("rst_reset_out", reset_out, 1);
        check("rst_ready", ready, 0);
        check("rst_counts", {lock_loss_count, timeout_count}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: cold start
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (pll_rst === 1'b1) cnt++;
            @(negedge clk);
        end
        check("t1_pll_rst_len", cnt, 4);
        pll_locked = 1'b1;
        wait_sig(2, 1'b0, 64, "t1_release", n);
        check("t1_release_lat", n, 12);
        check("t1_ready", ready, 1);
        check("t1_counts", {lock_loss_count, timeout_count}, 0);

        // 2: lock timeouts
        rst        = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rel = 0;
        for (int r = 0; r < 3; r++) begin
            wait_sig(1, 1'b0, 16, "t2_pll_rst_fall", n);
            lo = 0;
            while (pll_rst === 1'b0 && lo < 100) begin
                if (reset_out !== 1'b1) rel++;
                @(negedge clk);
                lo++;
            end
            check("t2_wait_len", lo, 32);
            hi = 0;
            while (pll_rst === 1'b1 && hi < 100) begin
                if (reset_out !== 1'b1) rel++;
                @(negedge clk);
                hi++;
            end
            check("t2_pulse_len", hi, 4);
        end
        check("t2_timeouts", timeout_count, 3);
        check("t2_no_release", rel, 0);

        // 3: one-cycle lock loss in RUN
        pll_locked = 1'b1;
        wait_sig(0, 1'b1, 64, "t3_ready", n);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_sig(2, 1'b1, 10, "t3_assert", n);
        tot = n + 1;
        check("t3_assert_lat_ok", (tot >= 3 && tot <= 4), 1);
        check("t3_pll_rst", pll_rst, 1);
        check("t3_lock_loss", lock_loss_count, 1);
        wait_sig(0, 1'b1, 64, "t3_relock", n);

        // 4: glitch during STABLE
        pll_locked = 1'b0;
        wait_sig(1, 1'b1, 10, "t4_pll_rst", n);
        pll_locked = 1'b1;
        wait_sig(1, 1'b0, 10, "t4_wait", n);
        repeat (4) @(negedge clk);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        wait_sig(0, 1'b1, 64, "t4_ready", n);
        check("t4_ready_lat", n, 12);
        check("t4_lock_loss", lock_loss_count, 2);
        check("t4_timeouts", timeout_count, 3);

        // 5: saturation, then clear against a simultaneous loss
        for (int i = 0; i < 17; i++) begin
            pll_locked = 1'b0;
            wait_sig(2, 1'b1, 10, "t5_loss", n);
            pll_locked = 1'b1;
            wait_sig(0, 1'b1, 64, "t5_relock", n);
        end
        check("t5_saturated", lock_loss_count, 15);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        check("t5_loss_seen", reset_out, 1);
        check("t5_cleared", {lock_loss_count, timeout_count}, 0);
        pll_locked = 1'b1;
        wait_sig(0, 1'b1, 64, "t5_relock2", n);

        // 6: reset while running
        pll_locked = 1'b0;
        wait_sig(2, 1'b1, 10, "t6_loss", n);
        pll_locked = 1'b1;
        wait_sig(0, 1'b1, 64, "t6_ready", n);
        check("t6_pre_count", lock_loss_count, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_ready", ready, 0);
        check("t6_reset_out", reset_out, 1);
        check("t6_pll_rst", pll_rst, 1);
        check("t6_counts", {lock_loss_count, timeout_count}, 0);
        rst = 1'b0;

        // Randomized lock traffic, clears and occasional resets
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                pll_locked = ~pll_locked;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                   : $urandom_range(5, 60);
            end
            hold--;
            clear_counts = ($urandom_range(0, 63) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst          = 1'b0;
        clear_counts = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
